// File: rtl/tick_timer_sched_if.sv
`default_nettype none
// ============================================================================
// Module   : tick_timer_sched_if
// Brief    : Valid/ready event port carrying the index of an expired channel.
// Revision : 1.0 - initial release
// ============================================================================
interface tick_timer_sched_if #(
    parameter int N_CH = 4,
    parameter int ID_W = $clog2(N_CH)
);
    logic            evt_valid;
    logic [ID_W-1:0] evt_id;
    logic            evt_ready;

    modport master (output evt_valid, output evt_id, input evt_ready);
    modport slave  (input evt_valid, input evt_id, output evt_ready);
endinterface
`default_nettype wire

// File: rtl/tick_timer_sched.sv
`default_nettype none
// ============================================================================
// Module   : tick_timer_sched
// Brief    : N one-shot tick timers; expiries are serialized round-robin onto
//            a single-entry valid/ready event register.
// Revision : 1.0 - initial release
// ============================================================================
module tick_timer_sched #(
    parameter int N_CH  = 4,
    parameter int DUR_W = 16
) (
    input  wire                 clk,
    input  wire                 reset,
    input  wire                 tick,
    input  wire  [N_CH-1:0]     start,
    input  wire  [DUR_W-1:0]    dur,
    input  wire  [N_CH-1:0]     cancel,
    output logic [N_CH-1:0]     busy,
    output logic [N_CH-1:0]     overrun,
    tick_timer_sched_if.master  evt
);
    localparam int               ID_W      = $clog2(N_CH);
    localparam logic [ID_W:0]    C_N_CH    = (ID_W+1)'(N_CH);
    localparam logic [ID_W-1:0]  C_LAST_ID = ID_W'(N_CH - 1);
    localparam logic [DUR_W-1:0] C_CNT_ONE = DUR_W'(1);

    logic [DUR_W-1:0] r_cnt [N_CH];
    logic [N_CH-1:0]  r_busy;
    logic [N_CH-1:0]  r_pending;
    logic [N_CH-1:0]  r_overrun;
    logic             r_evt_valid;
    logic [ID_W-1:0]  r_evt_id;
    logic [ID_W-1:0]  r_rr;

    logic [N_CH-1:0]  w_expire;
    logic [N_CH-1:0]  w_take;
    logic             w_load;
    logic             w_grant_vld;
    logic [ID_W-1:0]  w_grant_id;
    logic [ID_W-1:0]  w_rr_nxt;
    logic [ID_W:0]    w_sum;

    // start dominates cancel, cancel dominates tick; dur==0 expires immediately
    for (genvar i = 0; i < N_CH; i++) begin : g_expire
        assign w_expire[i] = start[i] ? (dur == '0)
                           : (!cancel[i] && tick && r_busy[i] && (r_cnt[i] == C_CNT_ONE));
    end

    assign w_load = !r_evt_valid || evt.evt_ready;

    // Descending scan so the lowest offset from r_rr is the final winner
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant_id  = '0;
        w_sum       = '0;
        for (int j = N_CH - 1; j >= 0; j--) begin
            w_sum = {1'b0, r_rr} + (ID_W+1)'(j);
            if (w_sum >= C_N_CH) begin
                w_sum = w_sum - C_N_CH;
            end
            if (r_pending[w_sum[ID_W-1:0]]) begin
                w_grant_vld = 1'b1;
                w_grant_id  = w_sum[ID_W-1:0];
            end
        end
    end

    always_comb begin
        w_take = '0;
        if (w_load && w_grant_vld) begin
            w_take[w_grant_id] = 1'b1;
        end
        w_rr_nxt = (w_grant_id == C_LAST_ID) ? '0 : w_grant_id + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_CH; i++) begin
                r_cnt[i] <= '0;
            end
            r_busy <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (start[i]) begin
                    r_cnt[i]  <= dur;
                    r_busy[i] <= (dur != '0);
                end else if (cancel[i]) begin
                    r_cnt[i]  <= '0;
                    r_busy[i] <= 1'b0;
                end else if (tick && r_busy[i]) begin
                    r_cnt[i]  <= r_cnt[i] - C_CNT_ONE;
                    r_busy[i] <= (r_cnt[i] != C_CNT_ONE);
                end
            end
        end
    end

    // An expiry landing on a channel that is being loaded this cycle is not an overrun
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pending   <= '0;
            r_overrun   <= '0;
            r_evt_valid <= 1'b0;
            r_evt_id    <= '0;
            r_rr        <= '0;
        end else begin
            r_pending <= (r_pending & ~w_take) | w_expire;
            r_overrun <= r_overrun | (w_expire & r_pending & ~w_take);
            if (w_load) begin
                r_evt_valid <= w_grant_vld;
                if (w_grant_vld) begin
                    r_evt_id <= w_grant_id;
                    r_rr     <= w_rr_nxt;
                end
            end
        end
    end

    assign busy          = r_busy;
    assign overrun       = r_overrun;
    assign evt.evt_valid = r_evt_valid;
    assign evt.evt_id    = r_evt_id;
endmodule
`default_nettype wire

// File: tb/tb_tick_timer_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_tick_timer_sched
// Brief    : Directed and randomized bench for tick_timer_sched with a
//            behavioural reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tick_timer_sched;
    localparam int N_CH  = 4;
    localparam int DUR_W = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic             tick;
    logic [N_CH-1:0]  start;
    logic [N_CH-1:0]  cancel;
    logic [DUR_W-1:0] dur;
    logic [N_CH-1:0]  busy;
    logic [N_CH-1:0]  overrun;

    tick_timer_sched_if #(.N_CH(N_CH)) evt_if ();

    tick_timer_sched #(.N_CH(N_CH), .DUR_W(DUR_W)) dut (
        .clk     (clk),
        .reset   (reset),
        .tick    (tick),
        .start   (start),
        .dur     (dur),
        .cancel  (cancel),
        .busy    (busy),
        .overrun (overrun),
        .evt     (evt_if.master)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int n_ticks = 0;
    int n_valid = 0;
    int tick_period = 0;
    int acc_q[$];

    // Reference model: remaining ticks per channel and a set of pending ids
    int            m_rem [N_CH];
    bit [N_CH-1:0] m_busy;
    bit [N_CH-1:0] m_pend;
    bit [N_CH-1:0] m_ovr;
    bit            m_vld;
    int            m_id;
    int            m_rr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_clock();
        bit [N_CH-1:0] expd;
        bit [N_CH-1:0] take;
        bit            load;
        int            k;
        expd = '0;
        take = '0;
        k    = -1;
        if (reset) begin
            for (int c = 0; c < N_CH; c++) m_rem[c] = 0;
            m_busy = '0; m_pend = '0; m_ovr = '0;
            m_vld = 1'b0; m_id = 0; m_rr = 0;
            return;
        end
        load = !m_vld || evt_if.evt_ready;
        if (load) begin
            for (int j = 0; j < N_CH; j++) begin
                if (k < 0 && m_pend[(m_rr + j) % N_CH]) k = (m_rr + j) % N_CH;
            end
        end
        for (int c = 0; c < N_CH; c++) begin
            if (start[c]) begin
                m_rem[c]  = int'(dur);
                m_busy[c] = (dur != 0);
                if (dur == 0) expd[c] = 1'b1;
            end else if (cancel[c]) begin
                m_rem[c]  = 0;
                m_busy[c] = 1'b0;
            end else if (tick && m_busy[c]) begin
                m_rem[c] = m_rem[c] - 1;
                if (m_rem[c] == 0) begin
                    m_busy[c] = 1'b0;
                    expd[c]   = 1'b1;
                end
            end
        end
        if (k >= 0) take[k] = 1'b1;
        m_ovr  = m_ovr | (expd & m_pend & ~take);
        m_pend = (m_pend & ~take) | expd;
        if (load) begin
            m_vld = (k >= 0);
            if (k >= 0) begin
                m_id = k;
                m_rr = (k + 1) % N_CH;
            end
        end
    endtask

    task automatic step();
        if (tick_period > 0) tick = ((cyc % tick_period) == tick_period - 1);
        if (tick) n_ticks++;
        if (evt_if.evt_valid) n_valid++;
        if (evt_if.evt_valid && evt_if.evt_ready) acc_q.push_back(int'(evt_if.evt_id));
        @(posedge clk);
        model_clock();
        cyc++;
        #1;
        chk("busy", busy, m_busy);
        chk("evt_valid", evt_if.evt_valid, m_vld);
        chk("evt_id", evt_if.evt_id, m_id);
        chk("overrun", overrun, m_ovr);
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic pulse(input logic [N_CH-1:0] s, input logic [N_CH-1:0] c, input int d);
        start = s; cancel = c; dur = DUR_W'(d);
        step();
        start = '0; cancel = '0;
    endtask

    task automatic tick_once();
        tick = 1'b1;
        step();
        tick = 1'b0;
    endtask

    task automatic wait_ticks(input int n);
        int t0;
        t0 = n_ticks;
        for (int g = 0; g < 1000 && n_ticks < t0 + n; g++) step();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int exp2 [6];
        exp2 = '{1, 2, 1, 2, 3, 0};
        reset = 1'b1; tick = 1'b0; start = '0; cancel = '0; dur = '0;
        evt_if.evt_ready = 1'b0;

        // Reset state
        do_reset();
        chk("rst_busy", busy, 0);
        chk("rst_valid", evt_if.evt_valid, 0);
        chk("rst_overrun", overrun, 0);

        // Single shot
        tick_period = 10;
        evt_if.evt_ready = 1'b1;
        n_valid = 0; acc_q.delete();
        pulse(4'b0001, 4'b0000, 3);
        chk("s1_busy", busy[0], 1);
        run(40);
        chk("s1_events", n_valid, 1);
        chk("s1_count", acc_q.size(), 1);
        if (acc_q.size() > 0) chk("s1_id", acc_q[0], 0);
        chk("s1_overrun", overrun, 0);

        // Round-robin ordering
        acc_q.delete();
        for (int r = 0; r < 3; r++) begin
            evt_if.evt_ready = 1'b0;
            pulse((r == 2) ? 4'b1001 : 4'b0110, 4'b0000, 1);
            run(15);
            evt_if.evt_ready = 1'b1;
            run(5);
        end
        chk("s2_count", acc_q.size(), 6);
        for (int i = 0; i < 6; i++) chk("s2_order", (i < acc_q.size()) ? acc_q[i] : -1, exp2[i]);

        // Cancel
        do_reset();
        pulse(4'b0001, 4'b0000, 5);
        wait_ticks(2);
        pulse(4'b0000, 4'b0001, 0);
        chk("s3_cancel_busy", busy[0], 0);
        n_valid = 0;
        wait_ticks(10);
        chk("s3_no_event", n_valid, 0);
        pulse(4'b0001, 4'b0001, 5);
        chk("s3_start_wins", busy[0], 1);

        // Overrun, then reset mid-operation
        do_reset();
        evt_if.evt_ready = 1'b0;
        for (int r = 0; r < 3; r++) begin
            pulse(4'b1000, 4'b0000, 1);
            wait_ticks(1);
            run(3);
        end
        chk("s4_overrun", overrun, 4'b1000);
        chk("s4_valid", evt_if.evt_valid, 1);
        chk("s4_id", evt_if.evt_id, 3);
        pulse(4'b1111, 4'b0000, 100);
        chk("s6_busy_pre", busy, 4'b1111);
        do_reset();
        chk("s6_busy", busy, 0);
        chk("s6_valid", evt_if.evt_valid, 0);
        chk("s6_overrun", overrun, 0);
        evt_if.evt_ready = 1'b1;
        n_valid = 0;
        run(300);
        chk("s6_no_event", n_valid, 0);

        // Edge timing with manual ticks
        tick_period = 0;
        tick = 1'b0;
        do_reset();
        start = 4'b0001; dur = 16'd2; tick = 1'b1;
        step();
        start = '0; tick = 1'b0;
        run(2);
        tick_once();
        chk("s5_coinc_busy1", busy[0], 1);
        run(2);
        tick_once();
        chk("s5_coinc_busy2", busy[0], 0);
        run(4);
        pulse(4'b0010, 4'b0000, 0);
        chk("s5_dur0_busy", busy[1], 0);
        chk("s5_dur0_valid_t1", evt_if.evt_valid, 0);
        step();
        chk("s5_dur0_valid_t2", evt_if.evt_valid, 1);
        chk("s5_dur0_id", evt_if.evt_id, 1);
        run(3);
        pulse(4'b0100, 4'b0000, 2);
        tick_once();
        pulse(4'b0100, 4'b0000, 4);
        n_valid = 0;
        repeat (3) begin
            tick_once();
            run(1);
        end
        chk("s5_retrig_busy", busy[2], 1);
        chk("s5_retrig_quiet", n_valid, 0);
        tick_once();
        chk("s5_retrig_done", busy[2], 0);
        run(3);
        chk("s5_retrig_event", n_valid, 1);

        // Randomized traffic against the model
        do_reset();
        for (int n = 0; n < 4000; n++) begin
            tick             = ($urandom_range(3) == 0);
            start            = ($urandom_range(7) == 0) ? N_CH'($urandom) : '0;
            cancel           = ($urandom_range(15) == 0) ? N_CH'($urandom) : '0;
            dur              = DUR_W'($urandom_range(6));
            evt_if.evt_ready = ($urandom_range(2) != 0);
            reset            = ($urandom_range(699) == 0);
            step();
        end
        reset = 1'b0; start = '0; cancel = '0; tick = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/tick_timer_sched.md
Name: tick_timer_sched

Overview:
- Multi-channel one-shot timer scheduler driven by the shared 10 us tick pulse from the system tick generator (1 tick every 1000 clk at 100 MHz).
- Each channel is started with a duration in ticks. It counts down on ticks and raises a pending event on expiry.
- Pending events are serialized round-robin onto a single valid/ready event port for the consuming controller or FSM.

Parameters:
N_CH, 4, number of timer channels (>=2); ID_W = $clog2(N_CH)
DUR_W, 16, duration width in ticks

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
tick  input  1  one-clk pulse from tick generator
start  input  N_CH  per-channel start/retrigger strobe
dur  input  DUR_W  duration loaded into every channel whose start bit is set this cycle
cancel  input  N_CH  per-channel abort strobe
busy  output  N_CH  channel counting
evt_valid  output  1  event available
evt_id  output  ID_W  expired channel index
evt_ready  input  1  consumer accepts event
overrun  output  N_CH  sticky: expiry lost because that channel was already pending

Behaviour:
- Reset (synchronous, clk edge with reset=1):
  - cnt, busy, pending, overrun cleared; evt_valid=0; evt_id=0; round-robin pointer rr=0.
  - Reset has priority over all inputs, including mid-count and mid-handshake.
- Per-channel priority each cycle: start > cancel > tick.
  - start[i], dur>0: cnt[i]<=dur, busy[i]<=1. Retrigger while busy reloads; there is no event for the aborted run. A tick in the same cycle is ignored for that channel.
  - start[i], dur==0: busy[i] stays 0; expiry (pending/overrun rules) occurs in the same cycle.
  - cancel[i] (no start): busy[i]<=0, cnt[i]<=0. pending[i] and any event already in the output register are untouched.
  - tick and busy[i]: if cnt[i]==1, busy[i]<=0 and expiry fires; else cnt[i]<=cnt[i]-1. A duration D therefore expires on the D-th tick strictly after the start cycle.
- Expiry of channel i:
  - pending[i]<=1.
  - If pending[i] is already 1 and not being consumed this cycle, overrun[i]<=1. overrun is sticky until reset.
- Output register (single entry):
  - load_en = !evt_valid || evt_ready.
  - If load_en and any pending: pick the first set bit searching rr, rr+1, … mod N_CH. Then evt_valid<=1, evt_id<=k, pending[k]<=0, rr<=(k+1) mod N_CH.
  - If load_en and none pending: evt_valid<=0.
  - A new expiry of k in the same cycle k is loaded keeps pending[k]=1, with no overrun.
- evt_id is stable while evt_valid && !evt_ready.
- Latency: expiry in cycle t -> pending at t+1 -> evt_valid at t+2 (if the output is free). Back-to-back accepts give 1 event per clk.
- Arithmetic: cnt is unsigned DUR_W. Max duration 2^DUR_W-1 ticks; no wrap, since counting stops at expiry.

Test Plan:
1. Single shot: tick every 10 clk. start[0] with dur=3, evt_ready=1.
   -> busy[0]=1 for 3 ticks. evt_valid=1 with evt_id=0 two clk after the 3rd tick, for exactly 1 clk. overrun=0.
2. Round-robin: start[1] and start[2] same cycle, dur=1, evt_ready=0 until both pending, then evt_ready=1.
   -> ids 1 then 2. Repeat the same scenario -> rr=3, so order is 1 then 2 again. Start ch0 and ch3 together with rr=3 -> id 3 then 0.
3. Cancel: start[0] dur=5, cancel[0] after 2 ticks.
   -> busy[0]=0 next clk; no event within 10 further ticks. start and cancel in the same cycle -> start wins, busy=1.
4. Overrun: evt_ready=0. start[3] dur=1 three times, each after the previous expiry.
   -> 1st expiry held in the output register (evt_valid=1, id 3); 2nd sets pending[3]; 3rd sets overrun[3]=1. Output stays id 3 until accepted.
5. Edge timing:
   - start coincident with tick, dur=2 -> expires on the 2nd subsequent tick.
   - dur=0 -> evt_valid 2 clk later, busy never set.
   - Retrigger at cnt=1 with dur=4 -> no event until 4 more ticks.
6. Reset mid-operation: assert reset with busy=4'b1111, evt_valid=1, overrun[3]=1.
   -> all outputs 0 the next clk. With no further starts, no event ever.
